// File: rtl/data_cache_ctrl.sv
// data_cache_ctrl: direct-mapped write-through no-write-allocate data cache; optional stats via DCACHE_STATS_EN
module data_cache_ctrl #(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUoutM,
    input  logic [31:0] RD2_Reg_File_aft_muxM,
    output logic [31:0] Mem_RDM,
    output logic        Mem_Stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IW = $clog2(LINES);
    localparam int OW = $clog2(WORDS_PER_LINE);
    localparam int TW = 32 - IW - OW - 2;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   cnt_q, cnt_d;
    logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0]     mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [31:0]     data_q [LINES][WORDS_PER_LINE];
    logic [TW-1:0]   tag_q [LINES];

    logic [OW-1:0] off;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic          rd, wr, hit, ack, fill_we, store_we;

    assign off      = ALUoutM[OW+1:2];
    assign idx      = ALUoutM[OW+IW+1:OW+2];
    assign tag      = ALUoutM[31:OW+IW+2];
    assign wr       = MemWriteM;
    assign rd       = MemReadM && !MemWriteM;
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);
    assign ack      = mem_req_q && mem_ready;
    assign fill_we  = (state_q == FILL) && ack;
    assign store_we = (state_q == IDLE) && wr && hit;

    assign Mem_RDM   = ((state_q == IDLE || state_q == DONE) && rd && hit) ? data_q[idx][off] : '0;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // next-state, request fields and stall; a line becomes valid only after its last word arrives
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        valid_d     = valid_q;
        Mem_Stall   = 1'b0;
        case (state_q)
            IDLE: begin
                Mem_Stall = wr || (rd && !hit);
                if (wr) begin
                    state_d     = WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ALUoutM & ~32'd3;
                    mem_wdata_d = RD2_Reg_File_aft_muxM;
                end else if (rd && !hit) begin
                    state_d    = FILL;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {tag, idx, {OW{1'b0}}, 2'b00};
                end
            end
            FILL: begin
                Mem_Stall = 1'b1;
                if (ack) begin
                    cnt_d      = cnt_q + OW'(1);
                    mem_addr_d = {mem_addr_q[31:OW+2], cnt_q + OW'(1), 2'b00};
                    if (&cnt_q) begin
                        mem_req_d    = 1'b0;
                        valid_d[idx] = 1'b1;
                        state_d      = DONE;
                    end
                end
            end
            WRITE: begin
                Mem_Stall = 1'b1;
                if (ack) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // control state; reset drops any outstanding request and invalidates every line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            valid_q     <= valid_d;
        end
    end

    // data and tag arrays carry no reset; the valid bits alone gate their use
    always_ff @(posedge clk) begin
        if (fill_we) data_q[idx][cnt_q] <= mem_rdata;
        if (fill_we && &cnt_q) tag_q[idx] <= tag;
        if (store_we) data_q[idx][off] <= RD2_Reg_File_aft_muxM;
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_q, miss_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

    // count idle-state read hits and fill launches only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (state_q == IDLE && rd && hit) hit_q <= hit_q + 32'd1;
            if (state_q == IDLE && rd && !hit) miss_q <= miss_q + 32'd1;
        end
    end
`endif
endmodule

// File: doc/data_cache_ctrl.md
Name: data_cache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache sitting directly downstream of the pipelined datapath's memory stage. It consumes ALUoutM, RD2_Reg_File_aft_muxM, MemReadM and MemWriteM. It produces Mem_RDM and Mem_Stall, which the datapath feeds into its M→W register and uses to freeze all pipeline registers. Misses and all writes are serviced via a word-wide request/ready handshake to main memory.

Parameters:
LINES, 64, number of cache lines (power of 2); index width IW = log2(LINES)
WORDS_PER_LINE, 4, 32-bit words per line (power of 2); offset width OW = log2(WORDS_PER_LINE)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
MemReadM  input  1  load in M stage
MemWriteM  input  1  store in M stage
ALUoutM  input  32  byte address
RD2_Reg_File_aft_muxM  input  32  store data
Mem_RDM  output  32  load data to datapath
Mem_Stall  output  1  freeze pipeline
mem_req  output  1  main-memory request valid
mem_we  output  1  1 = write, 0 = read
mem_addr  output  32  word-aligned byte address
mem_wdata  output  32  write data
mem_rdata  input  32  read data, valid with mem_ready
mem_ready  input  1  one-cycle completion of current request

Behaviour:
- Address split: [1:0] ignored; offset [OW+1:2]; index [OW+IW+1:OW+2]; tag = remaining upper bits.
- Storage: data array LINES×WORDS_PER_LINE×32, tag array, valid bits. Reset clears all valid bits only.
- hit = valid[index] && tag match.
- If MemReadM and MemWriteM are both 1, the access is treated as a write and the read is ignored.
- States: IDLE, FILL, WRITE, DONE. Reset state is IDLE.
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, fill counter=0, Mem_RDM=0 when no read hit.
- Mem_Stall is combinational:
  - In IDLE: 1 if (read && !hit) or write, else 0.
  - FILL/WRITE: 1.
  - DONE: 0.
- IDLE, read hit: Mem_RDM = array word, combinational, same cycle, no stall.
- IDLE, read miss → FILL, counter=0.
- IDLE, write → WRITE. On a hit, the cached word is updated on the same edge. On a miss, the cache is unchanged (no allocate).
- IDLE, no access: Mem_RDM = 0.
- FILL:
  - Registered request: mem_req=1, mem_we=0, mem_addr = {tag, index, counter, 2'b00}.
  - On mem_ready: store mem_rdata into word[counter] and increment counter.
  - After word WORDS_PER_LINE-1: write tag, set valid, drop mem_req, → DONE.
  - Words are fetched in order 0..N-1; no critical-word-first.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr = ALUoutM with [1:0]=0, mem_wdata = store data.
  - On mem_ready: drop mem_req, → DONE.
- DONE:
  - Exactly one cycle with stall low. A read returns the now-hit word; a write is not reissued; no new miss is detected.
  - Then → IDLE unconditionally.
- mem_req stays high and its fields stay stable until mem_ready. mem_ready while mem_req=0 is ignored.
- Inputs are held stable by the frozen pipeline while Mem_Stall=1.
- Reset mid-FILL/WRITE: immediately IDLE, mem_req=0, valid cleared. A partially filled line is never marked valid.
- Miss latency: 1 + WORDS_PER_LINE×(memory latency) + 1 (DONE) cycles.

Optional Feature:
DCACHE_STATS_EN:
- Defined: adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0, wrapping at 2^32.
  - hit_count increments once per IDLE read hit.
  - miss_count increments once per IDLE→FILL transition.
  - Writes and DONE-cycle reads are not counted.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Cold read of 0x0000_0040 with mem_ready one cycle after each request → 4 reads at 0x40, 0x44, 0x48, 0x4C; Mem_Stall high until DONE; Mem_RDM = memory word at 0x40 in DONE.
2. Read 0x0000_0048 after test 1 → hit; Mem_Stall=0 same cycle; Mem_RDM = word at 0x48; no mem_req.
3. Write 0xDEADBEEF to 0x44 (hit) → one mem write with mem_we=1 at 0x44; stall released in DONE; a later read of 0x44 hits and returns 0xDEADBEEF.
4. Write 0x12345678 to 0x0000_1000 (miss) → mem write issued; a later read of 0x1000 misses and triggers FILL (no allocate).
5. Conflict read 0x0000_0440 (same index as 0x40, different tag) → refill; the next read of 0x40 misses again.
6. Drive rst=0 during the 2nd FILL word → mem_req drops immediately; after release a read of the same address performs a full 4-word refill. With DCACHE_STATS_EN, hit_count and miss_count are both 0 after reset.
